// File: rtl/trees_chunk_scheduler.sv
// trees_chunk_scheduler: splits a tree-inference job into bank-sized chunks and
// sequences ping-pong loading, compute and prediction drain over DMA.
// Optional feature: define TREES_SCHED_PERF_EN to build the job cycle counter
// behind perf_cycles; otherwise perf_cycles is tied to zero.
module trees_chunk_scheduler #(
    parameter int unsigned N_FEATURE     = 32,
    parameter int unsigned MAX_BURST     = 5000,
    parameter int unsigned PRED_PER_WORD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] conf_total,
    input  logic [31:0] conf_chunk,
    input  logic [31:0] conf_out_base,
    input  logic        conf_done,
    output logic        acc_done,
    output logic        dma_read_ctrl_valid,
    input  logic        dma_read_ctrl_ready,
    output logic [31:0] dma_read_ctrl_data_index,
    output logic [31:0] dma_read_ctrl_data_length,
    input  logic        dma_read_chnl_valid,
    output logic        dma_read_chnl_ready,
    output logic        load_features,
    output logic        load_bank,
    output logic        compute_start,
    output logic        compute_bank,
    output logic [31:0] compute_len,
    input  logic        compute_done,
    output logic        dma_write_ctrl_valid,
    input  logic        dma_write_ctrl_ready,
    output logic [31:0] dma_write_ctrl_data_index,
    output logic [31:0] dma_write_ctrl_data_length,
    output logic        dma_write_chnl_valid,
    input  logic        dma_write_chnl_ready,
    output logic [31:0] perf_cycles
);

    localparam logic [31:0] NF         = 32'(N_FEATURE);
    localparam logic [31:0] MIN_CHUNK  = 32'(PRED_PER_WORD);
    localparam logic [31:0] MAX_CHUNK  = 32'(MAX_BURST);
    localparam logic [31:0] ALIGN_MASK = ~(32'(PRED_PER_WORD) - 32'd1);
    localparam logic [31:0] WORD_ROUND = 32'(PRED_PER_WORD) - 32'd1;
    localparam int unsigned WORD_SHIFT = $clog2(PRED_PER_WORD);

    typedef enum logic [1:0] {L_IDLE, L_REQ, L_DATA, L_NEXT} load_state_t;
    typedef enum logic [2:0] {C_IDLE, C_START, C_RUN, C_WREQ, C_WDATA} comp_state_t;

    load_state_t lstate, lnext;
    comp_state_t cstate, cnext;

    logic [31:0] total_r, chunk_r, out_base_r;
    logic [31:0] remaining, loaded_samples, done_samples;
    logic [31:0] bank_len [2];
    logic [31:0] rd_beats, beat_cnt, wr_beats, wbeat_cnt;
    logic [1:0]  bank_full;
    logic        job_active, zero_pending, acc_done_r;

    logic [31:0] chunk_clamped, chunk_eff, cur_chunk, rd_len_calc, wr_len_calc;
    logic        start, rd_beat, rd_last, wr_beat, wr_last;

    assign start       = conf_done && (lstate == L_IDLE) && (cstate == C_IDLE)
                         && !job_active && !zero_pending;
    assign cur_chunk   = (remaining < chunk_r) ? remaining : chunk_r;
    assign rd_len_calc = (cur_chunk * NF) >> 1;
    assign wr_len_calc = (bank_len[compute_bank] + WORD_ROUND) >> WORD_SHIFT;
    assign acc_done    = acc_done_r;
    assign compute_len = (cstate != C_IDLE) ? bank_len[compute_bank] : 32'd0;

    // Clamp the requested chunk size into [MIN, MAX] and align it to whole write words
    always_comb begin
        chunk_clamped = conf_chunk;
        if (conf_chunk == 32'd0)
            chunk_clamped = MAX_CHUNK;
        else if (conf_chunk < MIN_CHUNK)
            chunk_clamped = MIN_CHUNK;
        else if (conf_chunk > MAX_CHUNK)
            chunk_clamped = MAX_CHUNK;
        chunk_eff = chunk_clamped & ALIGN_MASK;
    end

    // State registers for the load and compute FSMs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lstate <= L_IDLE;
            cstate <= C_IDLE;
        end else begin
            lstate <= lnext;
            cstate <= cnext;
        end
    end

    // Load FSM: request a chunk read, accept its beats, then wait for a free bank
    always_comb begin
        lnext                     = lstate;
        dma_read_ctrl_valid       = 1'b0;
        dma_read_ctrl_data_index  = 32'd0;
        dma_read_ctrl_data_length = 32'd0;
        dma_read_chnl_ready       = 1'b0;
        load_features             = 1'b0;
        rd_beat                   = 1'b0;
        rd_last                   = 1'b0;
        case (lstate)
            L_IDLE: begin
                if (start && (conf_total != 32'd0))
                    lnext = L_REQ;
            end
            L_REQ: begin
                dma_read_ctrl_valid       = 1'b1;
                dma_read_ctrl_data_index  = (loaded_samples * NF) >> 1;
                dma_read_ctrl_data_length = rd_len_calc;
                if (dma_read_ctrl_ready)
                    lnext = L_DATA;
            end
            L_DATA: begin
                dma_read_chnl_ready = 1'b1;
                load_features       = 1'b1;
                if (dma_read_chnl_valid) begin
                    rd_beat = 1'b1;
                    if (beat_cnt == rd_beats - 32'd1) begin
                        rd_last = 1'b1;
                        lnext   = L_NEXT;
                    end
                end
            end
            L_NEXT: begin
                if (remaining == 32'd0)
                    lnext = L_IDLE;
                else if (!bank_full[load_bank])
                    lnext = L_REQ;
            end
            default: lnext = L_IDLE;
        endcase
    end

    // Compute FSM: start the datapath on a full bank, then drain its predictions
    always_comb begin
        cnext                      = cstate;
        compute_start              = 1'b0;
        dma_write_ctrl_valid       = 1'b0;
        dma_write_ctrl_data_index  = 32'd0;
        dma_write_ctrl_data_length = 32'd0;
        dma_write_chnl_valid       = 1'b0;
        wr_beat                    = 1'b0;
        wr_last                    = 1'b0;
        case (cstate)
            C_IDLE: begin
                if (bank_full[compute_bank])
                    cnext = C_START;
            end
            C_START: begin
                compute_start = 1'b1;
                cnext         = C_RUN;
            end
            C_RUN: begin
                if (compute_done)
                    cnext = C_WREQ;
            end
            C_WREQ: begin
                dma_write_ctrl_valid       = 1'b1;
                dma_write_ctrl_data_index  = out_base_r + (done_samples >> WORD_SHIFT);
                dma_write_ctrl_data_length = wr_len_calc;
                if (dma_write_ctrl_ready)
                    cnext = C_WDATA;
            end
            C_WDATA: begin
                dma_write_chnl_valid = 1'b1;
                if (dma_write_chnl_ready) begin
                    wr_beat = 1'b1;
                    if (wbeat_cnt == wr_beats - 32'd1) begin
                        wr_last = 1'b1;
                        cnext   = C_IDLE;
                    end
                end
            end
            default: cnext = C_IDLE;
        endcase
    end

    // Bank occupancy: a finished load fills its bank, a finished drain frees its bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= (bank_full | ({1'b0, rd_last} << load_bank))
                         & ~({1'b0, wr_last} << compute_bank);
        end
    end

    // Job bookkeeping: configuration capture, chunk progress, beat counters, completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_r        <= 32'd0;
            chunk_r        <= 32'd0;
            out_base_r     <= 32'd0;
            remaining      <= 32'd0;
            loaded_samples <= 32'd0;
            done_samples   <= 32'd0;
            bank_len[0]    <= 32'd0;
            bank_len[1]    <= 32'd0;
            rd_beats       <= 32'd0;
            beat_cnt       <= 32'd0;
            wr_beats       <= 32'd0;
            wbeat_cnt      <= 32'd0;
            load_bank      <= 1'b0;
            compute_bank   <= 1'b0;
            job_active     <= 1'b0;
            zero_pending   <= 1'b0;
            acc_done_r     <= 1'b0;
        end else begin
            acc_done_r <= 1'b0;
            if (start) begin
                total_r        <= conf_total;
                chunk_r        <= chunk_eff;
                out_base_r     <= conf_out_base;
                remaining      <= conf_total;
                loaded_samples <= 32'd0;
                done_samples   <= 32'd0;
                load_bank      <= 1'b0;
                compute_bank   <= 1'b0;
                if (conf_total == 32'd0)
                    zero_pending <= 1'b1;
                else
                    job_active <= 1'b1;
            end
            if (zero_pending) begin
                zero_pending <= 1'b0;
                acc_done_r   <= 1'b1;
            end
            if ((lstate == L_REQ) && dma_read_ctrl_ready) begin
                bank_len[load_bank] <= cur_chunk;
                rd_beats            <= rd_len_calc;
                beat_cnt            <= 32'd0;
                remaining           <= remaining - cur_chunk;
                loaded_samples      <= loaded_samples + cur_chunk;
            end
            if (rd_beat)
                beat_cnt <= beat_cnt + 32'd1;
            if (rd_last && (remaining != 32'd0))
                load_bank <= ~load_bank;
            if ((cstate == C_WREQ) && dma_write_ctrl_ready) begin
                wr_beats  <= wr_len_calc;
                wbeat_cnt <= 32'd0;
            end
            if (wr_beat)
                wbeat_cnt <= wbeat_cnt + 32'd1;
            if (wr_last) begin
                compute_bank <= ~compute_bank;
                done_samples <= done_samples + bank_len[compute_bank];
                if (done_samples + bank_len[compute_bank] == total_r) begin
                    job_active <= 1'b0;
                    acc_done_r <= 1'b1;
                end
            end
        end
    end

`ifdef TREES_SCHED_PERF_EN
    logic [31:0] perf_r;

    // Job cycle counter: clears on an accepted start, counts while active, holds afterwards
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            perf_r <= 32'd0;
        else if (start)
            perf_r <= 32'd0;
        else if (job_active || zero_pending)
            perf_r <= perf_r + 32'd1;
    end

    assign perf_cycles = perf_r;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_trees_chunk_scheduler.sv
// tb_trees_chunk_scheduler: directed bench for trees_chunk_scheduler with a DMA
// and datapath responder, an interface monitor and an independent bank-occupancy model.
module tb_trees_chunk_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] conf_total, conf_chunk, conf_out_base;
    logic        conf_done;
    logic        acc_done;
    logic        dma_read_ctrl_valid, dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index, dma_read_ctrl_data_length;
    logic        dma_read_chnl_valid, dma_read_chnl_ready;
    logic        load_features, load_bank;
    logic        compute_start, compute_bank;
    logic [31:0] compute_len;
    logic        compute_done;
    logic        dma_write_ctrl_valid, dma_write_ctrl_ready;
    logic [31:0] dma_write_ctrl_data_index, dma_write_ctrl_data_length;
    logic        dma_write_chnl_valid, dma_write_chnl_ready;
    logic [31:0] perf_cycles;

    int n_compared   = 0;
    int n_mismatched = 0;

    int cyc = 0;
    int conf_cyc, acc_cyc, last_wbeat_cyc;
    int acc_cnt, cs_cnt, ctrl_valid_cnt, unstable_cnt, full_viol;
    int rd_stall, wr_stall, rd_n, wr_n, drain_n;
    bit overlap_seen;
    logic [31:0] rd_idx_log [8];
    logic [31:0] rd_len_log [8];
    int          rd_cyc_log [8];
    logic [31:0] wr_idx_log [8];
    logic [31:0] wr_len_log [8];
    int          drain_cyc_log [8];
    logic [1:0]  tb_full;
    int          rd_left, wr_left;
    bit          rd_prev_pend, wr_prev_pend;
    logic [31:0] rd_prev_idx, rd_prev_len, wr_prev_idx, wr_prev_len;

    int cdelay;
    bit cd_pending;
    int cd_cnt;

    trees_chunk_scheduler dut (
        .clk                        (clk),
        .rst                        (rst),
        .conf_total                 (conf_total),
        .conf_chunk                 (conf_chunk),
        .conf_out_base              (conf_out_base),
        .conf_done                  (conf_done),
        .acc_done                   (acc_done),
        .dma_read_ctrl_valid        (dma_read_ctrl_valid),
        .dma_read_ctrl_ready        (dma_read_ctrl_ready),
        .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
        .dma_read_chnl_valid        (dma_read_chnl_valid),
        .dma_read_chnl_ready        (dma_read_chnl_ready),
        .load_features              (load_features),
        .load_bank                  (load_bank),
        .compute_start              (compute_start),
        .compute_bank               (compute_bank),
        .compute_len                (compute_len),
        .compute_done               (compute_done),
        .dma_write_ctrl_valid       (dma_write_ctrl_valid),
        .dma_write_ctrl_ready       (dma_write_ctrl_ready),
        .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
        .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
        .dma_write_chnl_valid       (dma_write_chnl_valid),
        .dma_write_chnl_ready       (dma_write_chnl_ready),
        .perf_cycles                (perf_cycles)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: answers each compute_start with compute_done after cdelay cycles
    always @(posedge clk) begin
        #1;
        compute_done = 1'b0;
        if (!rst) begin
            cd_pending = 1'b0;
        end else begin
            if (cd_pending) begin
                if (cd_cnt == 0) begin
                    compute_done = 1'b1;
                    cd_pending   = 1'b0;
                end else begin
                    cd_cnt = cd_cnt - 1;
                end
            end
            if (compute_start) begin
                cd_pending = 1'b1;
                cd_cnt     = cdelay;
            end
        end
    end

    // Interface monitor: logs handshakes, counts pulses and tracks bank occupancy mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            tb_full      = 2'b00;
            rd_left      = 0;
            wr_left      = 0;
            rd_prev_pend = 1'b0;
            wr_prev_pend = 1'b0;
        end else begin
            cyc = cyc + 1;
            if (conf_done) conf_cyc = cyc;
            if (acc_done) begin
                acc_cnt = acc_cnt + 1;
                acc_cyc = cyc;
            end
            if (compute_start) cs_cnt = cs_cnt + 1;
            if (dma_read_ctrl_valid || dma_write_ctrl_valid) ctrl_valid_cnt = ctrl_valid_cnt + 1;
            if (load_features && (compute_len != 32'd0)) overlap_seen = 1'b1;

            if (rd_prev_pend && (!dma_read_ctrl_valid || dma_read_ctrl_data_index != rd_prev_idx
                                 || dma_read_ctrl_data_length != rd_prev_len))
                unstable_cnt = unstable_cnt + 1;
            rd_prev_pend = dma_read_ctrl_valid && !dma_read_ctrl_ready;
            rd_prev_idx  = dma_read_ctrl_data_index;
            rd_prev_len  = dma_read_ctrl_data_length;
            if (wr_prev_pend && (!dma_write_ctrl_valid || dma_write_ctrl_data_index != wr_prev_idx
                                 || dma_write_ctrl_data_length != wr_prev_len))
                unstable_cnt = unstable_cnt + 1;
            wr_prev_pend = dma_write_ctrl_valid && !dma_write_ctrl_ready;
            wr_prev_idx  = dma_write_ctrl_data_index;
            wr_prev_len  = dma_write_ctrl_data_length;

            if (dma_read_ctrl_valid && !dma_read_ctrl_ready) rd_stall = rd_stall + 1;
            if (dma_write_ctrl_valid && !dma_write_ctrl_ready) wr_stall = wr_stall + 1;

            if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
                if (rd_n < 8) begin
                    rd_idx_log[rd_n] = dma_read_ctrl_data_index;
                    rd_len_log[rd_n] = dma_read_ctrl_data_length;
                    rd_cyc_log[rd_n] = cyc;
                end
                rd_n    = rd_n + 1;
                rd_left = int'(dma_read_ctrl_data_length);
            end
            if (load_features && dma_read_chnl_valid) begin
                if (tb_full[load_bank]) full_viol = full_viol + 1;
                if (rd_left > 0) begin
                    rd_left = rd_left - 1;
                    if (rd_left == 0) tb_full[load_bank] = 1'b1;
                end
            end

            if (dma_write_ctrl_valid && dma_write_ctrl_ready) begin
                if (wr_n < 8) begin
                    wr_idx_log[wr_n] = dma_write_ctrl_data_index;
                    wr_len_log[wr_n] = dma_write_ctrl_data_length;
                end
                wr_n    = wr_n + 1;
                wr_left = int'(dma_write_ctrl_data_length);
            end
            if (dma_write_chnl_valid && dma_write_chnl_ready && wr_left > 0) begin
                wr_left        = wr_left - 1;
                last_wbeat_cyc = cyc;
                if (wr_left == 0) begin
                    tb_full[compute_bank] = 1'b0;
                    if (drain_n < 8) drain_cyc_log[drain_n] = cyc;
                    drain_n = drain_n + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearLogs();
        acc_cnt = 0; cs_cnt = 0; ctrl_valid_cnt = 0; unstable_cnt = 0; full_viol = 0;
        rd_stall = 0; wr_stall = 0; rd_n = 0; wr_n = 0; drain_n = 0; overlap_seen = 1'b0;
        conf_cyc = -100; acc_cyc = -200; last_wbeat_cyc = -300;
        for (int i = 0; i < 8; i++) begin
            rd_idx_log[i] = 32'hDEAD; rd_len_log[i] = 32'hDEAD; rd_cyc_log[i] = -1;
            wr_idx_log[i] = 32'hDEAD; wr_len_log[i] = 32'hDEAD; drain_cyc_log[i] = -1;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] total, input logic [31:0] chunk, input logic [31:0] base);
        @(posedge clk); #1;
        conf_total    = total;
        conf_chunk    = chunk;
        conf_out_base = base;
        conf_done     = 1'b1;
        @(posedge clk); #1;
        conf_done     = 1'b0;
    endtask

    task automatic waitAcc(input string tag, input int budget);
        int k;
        k = 0;
        while (acc_cnt == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput(tag, acc_cnt, 1);
    endtask

    task automatic checkPerf(input string tag);
`ifdef TREES_SCHED_PERF_EN
        checkOutput(tag, perf_cycles, 32'(acc_cyc - conf_cyc - 1));
`else
        checkOutput(tag, perf_cycles, 32'd0);
`endif
    endtask

    initial begin
        int k;
        rst = 1'b0;
        conf_total = 0; conf_chunk = 0; conf_out_base = 0; conf_done = 1'b0;
        dma_read_ctrl_ready = 1'b1; dma_write_ctrl_ready = 1'b1;
        dma_read_chnl_valid = 1'b1; dma_write_chnl_ready = 1'b1;
        compute_done = 1'b0; cdelay = 10;
        clearLogs();

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rd_valid", dma_read_ctrl_valid, 0);
        checkOutput("rst_wr_valid", dma_write_ctrl_valid, 0);
        checkOutput("rst_misc", {acc_done, load_features, load_bank, compute_start, compute_bank,
                                 dma_read_chnl_ready, dma_write_chnl_valid}, 0);
        checkOutput("rst_perf", perf_cycles, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Single chunk job
        clearLogs();
        applyStimulus(16, 16, 100);
        waitAcc("t1_acc", 3000);
        checkOutput("t1_rd_n", rd_n, 1);
        checkOutput("t1_rd_idx", rd_idx_log[0], 0);
        checkOutput("t1_rd_len", rd_len_log[0], 256);
        checkOutput("t1_wr_n", wr_n, 1);
        checkOutput("t1_wr_idx", wr_idx_log[0], 100);
        checkOutput("t1_wr_len", wr_len_log[0], 2);
        checkOutput("t1_cs_cnt", cs_cnt, 1);
        checkOutput("t1_acc_lat", 32'(acc_cyc - last_wbeat_cyc), 1);
        checkPerf("t1_perf");

        // Three chunks with a short tail and overlapping load/compute
        clearLogs();
        applyStimulus(20, 8, 200);
        waitAcc("t2_acc", 3000);
        checkOutput("t2_rd_n", rd_n, 3);
        checkOutput("t2_rd_idx1", rd_idx_log[1], 128);
        checkOutput("t2_rd_idx2", rd_idx_log[2], 256);
        checkOutput("t2_rd_len0", rd_len_log[0], 128);
        checkOutput("t2_rd_len2", rd_len_log[2], 64);
        checkOutput("t2_wr_n", wr_n, 3);
        checkOutput("t2_wr_idx0", wr_idx_log[0], 200);
        checkOutput("t2_wr_idx1", wr_idx_log[1], 201);
        checkOutput("t2_wr_idx2", wr_idx_log[2], 202);
        checkOutput("t2_wr_len2", wr_len_log[2], 1);
        checkOutput("t2_cs_cnt", cs_cnt, 3);
        checkOutput("t2_overlap", overlap_seen, 1);

        // Slow datapath: third load must wait for bank 0 to drain
        clearLogs();
        cdelay = 1000;
        applyStimulus(24, 8, 0);
        waitAcc("t3_acc", 6000);
        cdelay = 10;
        checkOutput("t3_rd_n", rd_n, 3);
        checkOutput("t3_rd1_early", rd_cyc_log[1] < drain_cyc_log[0], 1);
        checkOutput("t3_rd2_waits", rd_cyc_log[2] > drain_cyc_log[0], 1);
        checkOutput("t3_full_viol", full_viol, 0);

        // Chunk clamping: small request rounds up to one word, zero selects the bank size
        clearLogs();
        applyStimulus(16, 3, 0);
        waitAcc("t4a_acc", 3000);
        checkOutput("t4a_rd_n", rd_n, 2);
        checkOutput("t4a_rd_len1", rd_len_log[1], 128);
        clearLogs();
        applyStimulus(16, 0, 0);
        waitAcc("t4b_acc", 3000);
        checkOutput("t4b_rd_n", rd_n, 1);
        checkOutput("t4b_rd_len", rd_len_log[0], 256);

        // Back-pressure on both request channels
        clearLogs();
        dma_read_ctrl_ready = 1'b0;
        dma_write_ctrl_ready = 1'b0;
        applyStimulus(16, 16, 50);
        repeat (50) @(posedge clk);
        #1;
        dma_read_ctrl_ready = 1'b1;
        k = 0;
        while (!dma_write_ctrl_valid && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (50) @(posedge clk);
        #1;
        dma_write_ctrl_ready = 1'b1;
        waitAcc("t5_acc", 3000);
        checkOutput("t5_unstable", unstable_cnt, 0);
        checkOutput("t5_rd_stall", rd_stall >= 50, 1);
        checkOutput("t5_wr_stall", wr_stall >= 50, 1);
        checkOutput("t5_rd_n", rd_n, 1);
        checkOutput("t5_wr_n", wr_n, 1);
        checkOutput("t5_wr_idx", wr_idx_log[0], 50);

        // Empty job
        clearLogs();
        applyStimulus(0, 8, 0);
        waitAcc("t6_acc", 50);
        checkOutput("t6_ctrl_valid", ctrl_valid_cnt, 0);
        checkOutput("t6_acc_lat", 32'(acc_cyc - conf_cyc), 2);
        checkPerf("t6_perf");

        // Reset in the middle of a load, then a clean job
        clearLogs();
        applyStimulus(64, 64, 0);
        k = 0;
        while (!load_features && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        checkOutput("t7_in_load", load_features, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t7_rst_valids", {dma_read_ctrl_valid, dma_write_ctrl_valid, dma_read_chnl_ready,
                                      load_features, compute_start, dma_write_chnl_valid, acc_done}, 0);
        checkOutput("t7_rst_rd_len", dma_read_ctrl_data_length, 0);
        checkOutput("t7_rst_cmp_len", compute_len, 0);
        checkOutput("t7_rst_perf", perf_cycles, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        clearLogs();
        applyStimulus(16, 16, 300);
        waitAcc("t7_acc", 3000);
        checkOutput("t7_rd_idx", rd_idx_log[0], 0);
        checkOutput("t7_rd_len", rd_len_log[0], 256);
        checkOutput("t7_wr_idx", wr_idx_log[0], 300);
        checkOutput("t7_cs_cnt", cs_cnt, 1);
        checkPerf("t7_perf");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
